// File: rtl/rf_pkg.sv
// Shared constants and write-request type for the register-file write path.
// Default parameter values for the write arbiter and its result buffer.
package rf_pkg;

  localparam int DATA_W       = 16;
  localparam int ADDR_W       = 2;
  localparam int NUM_REGS     = 1 << ADDR_W;
  localparam int FIFO_DEPTH   = 2;
  localparam int STARVE_LIMIT = 3;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [ADDR_W-1:0] rd);
    return NUM_REGS'(1) << rd;
  endfunction

endpackage

// File: rtl/rf_wr_fifo.sv
// Synchronous FIFO of {rd, data} multi-cycle results.
// Per-slot valid and rd vectors are exported so the arbiter can build its pending mask.
module rf_wr_fifo #(
  parameter int RD_W   = 2,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [RD_W-1:0]             push_rd,
  input  logic [DATA_W-1:0]           push_data,
  input  logic                        pop,
  output logic [RD_W-1:0]             head_rd,
  output logic [DATA_W-1:0]           head_data,
  output logic [CNT_W-1:0]            count,
  output logic                        full,
  output logic                        empty,
  output logic [DEPTH-1:0]            ent_valid,
  output logic [DEPTH-1:0][RD_W-1:0]  ent_rd
);

  logic [RD_W-1:0]   rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push, do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  // A full buffer refuses pushes even when it pops in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_rd   = rd_mem[rd_ptr_reg];
  assign head_data = data_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      rd_mem[wr_ptr_reg]   <= push_rd;
      data_mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Slot gi holds live data when its distance from the read pointer is below count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PTR_W-1:0] offset;
      assign offset        = PTR_W'(gi) - rd_ptr_reg;
      assign ent_valid[gi] = (CNT_W'(offset) < count_reg);
      assign ent_rd[gi]    = rd_mem[gi];
    end
  endgenerate

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between write-back and buffered multi-cycle results,
// with a starvation counter that forces a buffer slot and stalls write-back.
module rf_write_arbiter #(
  parameter int DATA_W       = rf_pkg::DATA_W,
  parameter int ADDR_W       = rf_pkg::ADDR_W,
  parameter int FIFO_DEPTH   = rf_pkg::FIFO_DEPTH,
  parameter int STARVE_LIMIT = rf_pkg::STARVE_LIMIT,
  localparam int NUM_REGS    = 1 << ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wb_we,
  input  logic [ADDR_W-1:0]   wb_rd,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                mu_valid,
  input  logic [ADDR_W-1:0]   mu_rd,
  input  logic [DATA_W-1:0]   mu_data,
  output logic                mu_ready,
  output logic                stall_wb,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_wa,
  output logic [DATA_W-1:0]   rf_wd,
  output logic [NUM_REGS-1:0] pend_mask
);
  import rf_pkg::*;

  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic                                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ADDR_W-1:0]                   head_rd;
  logic [DATA_W-1:0]                   head_data;
  logic [CNT_W-1:0]                    fifo_count;
  logic [FIFO_DEPTH-1:0]               ent_valid;
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0]   ent_rd;

  logic                has_head, force_buf, grant_wb, grant_buf;
  logic [STARVE_W-1:0] starve_cnt_reg, starve_cnt_next;
  logic                rf_we_reg, rf_we_next;
  logic [ADDR_W-1:0]   rf_wa_reg, rf_wa_next;
  logic [DATA_W-1:0]   rf_wd_reg, rf_wd_next;

  assign mu_ready  = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign fifo_push = mu_valid && !fifo_full && !reset;
  assign fifo_pop  = grant_buf && !reset;

  rf_wr_fifo #(
    .RD_W   (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_rd   (mu_rd),
    .push_data (mu_data),
    .pop       (fifo_pop),
    .head_rd   (head_rd),
    .head_data (head_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ent_valid (ent_valid),
    .ent_rd    (ent_rd)
  );

  always_comb begin
    has_head  = !fifo_empty;
    force_buf = has_head && (starve_cnt_reg == STARVE_MAX);
    grant_wb  = wb_we && !force_buf;
    grant_buf = has_head && (!wb_we || force_buf);
    stall_wb  = !reset && wb_we && force_buf;
  end

  // The counter only advances while a buffered result loses to write-back.
  always_comb begin
    starve_cnt_next = '0;
    if (has_head && grant_wb) begin
      if (starve_cnt_reg != STARVE_MAX) starve_cnt_next = starve_cnt_reg + STARVE_W'(1);
      else                              starve_cnt_next = STARVE_MAX;
    end
  end

  // Address and data hold their last value on idle cycles; only rf_we drops.
  always_comb begin
    rf_we_next = grant_wb || grant_buf;
    rf_wa_next = rf_wa_reg;
    rf_wd_next = rf_wd_reg;
    if (grant_wb) begin
      rf_wa_next = wb_rd;
      rf_wd_next = wb_data;
    end else if (grant_buf) begin
      rf_wa_next = head_rd;
      rf_wd_next = head_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_reg <= '0;
      rf_we_reg      <= 1'b0;
      rf_wa_reg      <= '0;
      rf_wd_reg      <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      rf_we_reg      <= rf_we_next;
      rf_wa_reg      <= rf_wa_next;
      rf_wd_reg      <= rf_wd_next;
    end
  end

  assign rf_we = rf_we_reg;
  assign rf_wa = rf_wa_reg;
  assign rf_wd = rf_wd_reg;

  // Destinations still owed to the register file: buffered entries plus the write in flight.
  always_comb begin
    pend_mask = '0;
    for (int e = 0; e < FIFO_DEPTH; e++) begin
      if (ent_valid[e]) pend_mask[ent_rd[e]] = 1'b1;
    end
    if (rf_we_reg) pend_mask[rf_wa_reg] = 1'b1;
  end

endmodule
